// File: rtl/rv32e_mem_arbiter.sv
// rv32e_mem_arbiter
//   Shares one single-port memory between the CPU fetch port (i_*) and the
//   data port (d_*). Each request is latched into registered mem_* outputs,
//   held until mem_ack (or a timeout), and completed with a one-cycle ready
//   pulse carrying the captured read data. dmem has fixed priority over imem.
//
// Parameters
//   TIMEOUT_CYCLES  grant cycles without mem_ack before aborting (1..65535)
//   STARVE_LIMIT    consecutive dmem grants allowed while imem waits
//                   (used only when MEM_ARB_STARVE_GUARD_EN is defined)
//
// Build option
//   MEM_ARB_STARVE_GUARD_EN  grant imem after STARVE_LIMIT back-to-back dmem
//                            grants taken while i_req was pending
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   i_req/i_addr          fetch request (held until i_ready)
//   i_rdata/i_ready       fetched word / one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata/d_be  data request (held until d_ready)
//   d_rdata/d_ready       load data (0 for stores) / completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be  registered memory request
//   mem_rdata/mem_ack     memory read data / one-cycle completion
//   err                   pulses with ready when the transaction timed out
//   busy                  high whenever the FSM is not IDLE
module rv32e_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_D = 2'd1,
    GRANT_I = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Timeout fires on the grant cycle where the count of earlier ack-less
  // cycles is TIMEOUT_CYCLES-1, so mem_req is high exactly TIMEOUT_CYCLES cycles.
  localparam logic [15:0] TLAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] tcount_q;
  logic [31:0] rdata_q;
  logic        i_ready_q, d_ready_q, err_q;
  logic        grant_d, grant_i, ack_done, time_done;
  logic        starve_hit;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned SW = ($clog2(STARVE_LIMIT + 1) > 4) ? $clog2(STARVE_LIMIT + 1) : 4;
  logic [SW-1:0] starve_q;

  assign starve_hit = (starve_q == SW'(STARVE_LIMIT));

  // Counts dmem grants won while imem was also waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else if (state_q == IDLE) begin
      if (grant_i || !i_req) begin
        starve_q <= '0;
      end else if (grant_d) begin
        starve_q <= starve_q + SW'(1);
      end
    end
  end
`else
  assign starve_hit = 1'b0 && (STARVE_LIMIT != 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    ack_done  = 1'b0;
    time_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_req && !(i_req && starve_hit)) begin
          grant_d = 1'b1;
          state_d = GRANT_D;
        end else if (i_req) begin
          grant_i = 1'b1;
          state_d = GRANT_I;
        end
      end
      GRANT_D, GRANT_I: begin
        if (mem_ack) begin
          ack_done = 1'b1;
          state_d  = DONE;
        end else if (tcount_q == TLAST) begin
          time_done = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      tcount_q  <= '0;
      rdata_q   <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      err_q     <= 1'b0;

      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_be    <= d_be;
        tcount_q  <= '0;
      end

      if (grant_i) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
        mem_be    <= '1;
        tcount_q  <= '0;
      end

      if ((state_q == GRANT_D || state_q == GRANT_I) && !ack_done && !time_done) begin
        tcount_q <= tcount_q + 16'd1;
      end

      if (ack_done) begin
        mem_req   <= 1'b0;
        rdata_q   <= mem_we ? '0 : mem_rdata;
        i_ready_q <= (state_q == GRANT_I);
        d_ready_q <= (state_q == GRANT_D);
      end

      if (time_done) begin
        mem_req   <= 1'b0;
        rdata_q   <= '0;
        i_ready_q <= (state_q == GRANT_I);
        d_ready_q <= (state_q == GRANT_D);
        err_q     <= 1'b1;
      end
    end
  end

  assign i_ready = i_ready_q;
  assign d_ready = d_ready_q;
  assign i_rdata = i_ready_q ? rdata_q : '0;
  assign d_rdata = d_ready_q ? rdata_q : '0;
  assign err     = err_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_rv32e_mem_arbiter.sv
// Scoreboard bench for rv32e_mem_arbiter: stimulus pushes the expected memory
// request and completion; a monitor pops and compares when the DUT shows them.
module tb_rv32e_mem_arbiter;

  localparam int unsigned TOUT = 8;

  logic        clk, reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic [31:0] i_rdata, d_rdata;
  logic        i_ready, d_ready;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        err, busy;

  rv32e_mem_arbiter #(.TIMEOUT_CYCLES(TOUT), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err(err), .busy(busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // memory responder controls
  logic        ack_en;
  int          ack_delay;
  logic [31:0] resp_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: acks ack_delay negedges after mem_req is first seen.
  initial begin
    int  wcnt;
    bit  acked;
    wcnt      = 0;
    acked     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (!mem_req) begin
        wcnt  = 0;
        acked = 1'b0;
      end else if (ack_en && !acked) begin
        if (wcnt == ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = resp_data;
          acked     = 1'b1;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic prev_mem_req, prev_busy;
    int   req_len;
    req_t er;
    rsp_t es;
    prev_mem_req = 1'b0;
    prev_busy    = 1'b0;
    req_len      = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        prev_mem_req = 1'b0;
        prev_busy    = 1'b0;
        req_len      = 0;
      end else begin
        if (mem_req && !prev_mem_req) begin
          chk("req_issued_from_idle", 32'(prev_busy), 32'd0);
          if (exp_req.size() == 0) begin
            bound_fail("unexpected_mem_req");
          end else begin
            er = exp_req.pop_front();
            chk("mem_addr", mem_addr, er.addr);
            chk("mem_we", 32'(mem_we), 32'(er.we));
            chk("mem_be", 32'(mem_be), 32'(er.be));
            chk("mem_wdata", mem_wdata, er.wdata);
          end
        end
        if (mem_req) req_len++;
        if (prev_mem_req && !mem_req) begin
          if (!mem_ack) chk("timeout_grant_cycles", 32'(req_len), 32'(TOUT));
          req_len = 0;
        end
        if (i_ready || d_ready) begin
          chk("ready_overlap", 32'(i_ready & d_ready), 32'd0);
          chk("ready_with_req_release", 32'(prev_mem_req && !mem_req), 32'd1);
          if (exp_rsp.size() == 0) begin
            bound_fail("unexpected_ready");
          end else begin
            es = exp_rsp.pop_front();
            chk("ready_port_is_d", 32'(d_ready), 32'(es.is_d));
            chk("rdata", d_ready ? d_rdata : i_rdata, es.rdata);
            chk("err", 32'(err), 32'(es.err));
          end
        end
        prev_mem_req = mem_req;
        prev_busy    = busy;
      end
    end
  end

  task automatic wait_rsp(input int target, input int budget, input string name);
    int cyc;
    cyc = 0;
    while (exp_rsp.size() > target && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_rsp.size() > target) bound_fail(name);
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (busy) bound_fail(name);
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset     = 1'b0;
    i_req     = 1'b0;
    i_addr    = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    d_be      = '0;
    ack_en    = 1'b1;
    ack_delay = 0;
    resp_data = '0;

    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_i_ready", 32'(i_ready), 32'd0);
    chk("rst_d_ready", 32'(d_ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Fetch, ack two cycles after mem_req
    ack_delay = 2;
    resp_data = 32'h0050_0093;
    exp_req.push_back('{32'h100, 1'b0, 4'hF, 32'h0});
    exp_rsp.push_back('{1'b0, 32'h0050_0093, 1'b0});
    i_addr = 32'h100;
    i_req  = 1'b1;
    wait_rsp(0, 50, "fetch_done");
    i_req = 1'b0;
    wait_idle("fetch_idle");

    // Store, immediate ack; read data must come back zero
    ack_delay = 0;
    resp_data = 32'hDEAD_BEEF;
    exp_req.push_back('{32'h2004, 1'b1, 4'b0011, 32'hCAFE_BABE});
    exp_rsp.push_back('{1'b1, 32'h0, 1'b0});
    d_we    = 1'b1;
    d_addr  = 32'h2004;
    d_wdata = 32'hCAFE_BABE;
    d_be    = 4'b0011;
    d_req   = 1'b1;
    wait_rsp(0, 50, "store_done");
    d_req = 1'b0;
    d_we  = 1'b0;
    wait_idle("store_idle");

    // Simultaneous requests: dmem first, then imem
    resp_data = 32'h0000_0A0A;
    exp_req.push_back('{32'h80, 1'b0, 4'hF, 32'h0});
    exp_req.push_back('{32'h40, 1'b0, 4'hF, 32'h0});
    exp_rsp.push_back('{1'b1, 32'h0000_0A0A, 1'b0});
    exp_rsp.push_back('{1'b0, 32'h0000_0A0A, 1'b0});
    d_addr  = 32'h80;
    d_be    = 4'hF;
    d_wdata = 32'h0;
    i_addr  = 32'h40;
    d_req   = 1'b1;
    i_req   = 1'b1;
    wait_rsp(1, 50, "both_d_done");
    d_req = 1'b0;
    wait_rsp(0, 50, "both_i_done");
    i_req = 1'b0;
    wait_idle("both_idle");

    // Timeout: no ack ever arrives
    ack_en = 1'b0;
    exp_req.push_back('{32'h200, 1'b0, 4'hF, 32'h0});
    exp_rsp.push_back('{1'b0, 32'h0, 1'b1});
    i_addr = 32'h200;
    i_req  = 1'b1;
    wait_rsp(0, 50, "timeout_done");
    i_req = 1'b0;
    wait_idle("timeout_idle");

    // Reset in the middle of a dmem grant
    exp_req.push_back('{32'h300, 1'b0, 4'hF, 32'h0});
    d_addr = 32'h300;
    d_req  = 1'b1;
    cyc = 0;
    while (!mem_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!mem_req) bound_fail("reset_test_grant");
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_mem_req", 32'(mem_req), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_i_ready", 32'(i_ready), 32'd0);
    chk("async_rst_d_ready", 32'(d_ready), 32'd0);
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    ack_en    = 1'b1;
    ack_delay = 1;
    resp_data = 32'h0BAD_F00D;
    exp_req.push_back('{32'h304, 1'b0, 4'hF, 32'h0});
    exp_rsp.push_back('{1'b1, 32'h0BAD_F00D, 1'b0});
    d_addr = 32'h304;
    d_req  = 1'b1;
    wait_rsp(0, 50, "post_reset_done");
    d_req = 1'b0;
    wait_idle("post_reset_idle");

    // Both requesters held continuously for ten grants
    ack_delay = 0;
    resp_data = 32'h1122_3344;
    for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      if (k == 4 || k == 9) begin
        exp_req.push_back('{32'h40, 1'b0, 4'hF, 32'h0});
        exp_rsp.push_back('{1'b0, 32'h1122_3344, 1'b0});
      end else begin
        exp_req.push_back('{32'h80, 1'b0, 4'hF, 32'h0});
        exp_rsp.push_back('{1'b1, 32'h1122_3344, 1'b0});
      end
`else
      exp_req.push_back('{32'h80, 1'b0, 4'hF, 32'h0});
      exp_rsp.push_back('{1'b1, 32'h1122_3344, 1'b0});
`endif
    end
    d_addr = 32'h80;
    i_addr = 32'h40;
    d_req  = 1'b1;
    i_req  = 1'b1;
    wait_rsp(0, 200, "starve_done");
    d_req = 1'b0;
    i_req = 1'b0;
    wait_idle("starve_idle");
    repeat (3) @(negedge clk);

    if (exp_req.size() != 0) bound_fail("leftover_mem_requests");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
